// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// imemData is valid in the same cycle that imemReady acknowledges imemReq.
interface fetch_unit_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemData
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: request a word, hold it until committed,
// then advance the PC or trap on a misaligned next PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch,
    input  logic                forceJump,
    input  logic                zero,
    input  logic [31:0]         target,
    fetch_unit_if.master        imem,
    output logic [31:0]         instr,
    output logic [6:0]          opCode,
    output logic                instrValid,
    output logic [31:0]         pc,
    output logic [31:0]         pcPlus4,
    output logic                misaligned,
    output logic [31:0]         instrCount
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        commit;
    logic        take;
    logic        next_aligned;
    logic [31:0] next_pc;

    assign pcPlus4       = pc + 32'd4;
    assign opCode        = instr[6:0];
    assign imem.imemAddr = pc;

    // Redirect only on a committed jump or a taken branch; sums wrap silently.
    assign take         = forceJump | (branch & zero);
    assign next_pc      = take ? target : pcPlus4;
    assign next_aligned = (next_pc[1:0] == 2'b00);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Outputs depend only on the registered state, never on imemReady or stall.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_next      = state;
        imem.imemReq    = 1'b0;
        instrValid      = 1'b0;
        misaligned      = 1'b0;
        commit          = 1'b0;
        case (state)
            S_REQ: begin
                imem.imemReq = 1'b1;
                if (imem.imemReady) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                instrValid = 1'b1;
                if (!stall) begin
                    commit     = 1'b1;
                    state_next = next_aligned ? S_REQ : S_TRAP;
                end
            end
            S_TRAP: begin
                misaligned = 1'b1;
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            instr      <= NOP;
            instrCount <= 32'd0;
        end else begin
            if (state == S_REQ && imem.imemReady) begin
                instr <= imem.imemData;
            end
            if (commit) begin
                instrCount <= instrCount + 32'd1;
                // A misaligned target is counted but never becomes the PC.
                if (next_aligned) begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 Port stall  input  1  SHALL hold the current instruction when high (no commit).
REQ-005 Port branch  input  1  SHALL be the branch control from Control.
REQ-006 Port forceJump  input  1  SHALL be the unconditional jump control from Control.
REQ-007 Port zero  input  1  SHALL be the ALU branch-condition result.
REQ-008 Port target  input  32  SHALL be the computed branch/jump target address.
REQ-009 Port imemReq  output  1  SHALL request an instruction word from instruction memory.
REQ-010 Port imemAddr  output  32  SHALL be the fetch address; equals pc.
REQ-011 Port imemReady  input  1  SHALL acknowledge imemReq with imemData valid in the same cycle.
REQ-012 Port imemData  input  32  SHALL be the returned instruction word.
REQ-013 Port instr  output  32  SHALL be the registered current instruction.
REQ-014 Port opCode  output  7  SHALL equal instr[6:0]; it feeds Control.
REQ-015 Port instrValid  output  1  SHALL be high while instr is valid for execution.
REQ-016 Port pc  output  32  SHALL be the address of the current instruction.
REQ-017 Port pcPlus4  output  32  SHALL equal pc + 4, modulo 2^32.
REQ-018 Port misaligned  output  1  SHALL flag a trap on a misaligned next PC.
REQ-019 Port instrCount  output  32  SHALL count committed instructions.

Function
REQ-020 FSM states SHALL be REQ, HOLD and TRAP, with outputs decoded from registered state only.
REQ-021 In REQ: imemReq=1 and instrValid=0; on imemReady=1, instr<=imemData and the state SHALL go to HOLD next cycle.
REQ-022 In REQ with imemReady=0, the FSM SHALL stay in REQ indefinitely, with pc and imemAddr stable.
REQ-023 In HOLD: instrValid=1 and imemReq=0; imemReady SHALL be ignored.
REQ-024 Commit SHALL occur in a cycle with state HOLD and stall=0.
REQ-025 On commit, nextPC SHALL be target if (forceJump | (branch & zero)), else pcPlus4.
REQ-026 On commit with nextPC[1:0]==2'b00: pc<=nextPC, instrCount<=instrCount+1 (wraps 2^32-1 -> 0), and the state SHALL go to REQ.
REQ-027 On commit with nextPC[1:0]!=2'b00: pc holds, instrCount increments, and the state SHALL go to TRAP.
REQ-028 In HOLD with stall=1: pc, instr and instrCount SHALL hold, and the state SHALL stay in HOLD.
REQ-029 In TRAP: misaligned=1, instrValid=0 and imemReq=0; the FSM SHALL stay in TRAP until reset.
REQ-030 misaligned SHALL be 0 in every state other than TRAP.
REQ-031 Minimum fetch-to-commit latency SHALL be 2 cycles (REQ with ready=1, then HOLD with stall=0).
REQ-032 pc increment and target SHALL wrap modulo 2^32 without flagging.
REQ-033 branch=1 with zero=0 SHALL select pcPlus4, regardless of target alignment.

Reset
REQ-034 While reset=1 at a clock edge: state<=REQ, pc<=RESET_PC, instr<=32'h0000_0013 (NOP), instrCount<=0.
REQ-035 The first cycle after reset SHALL present imemReq=1, imemAddr=RESET_PC, instrValid=0 and misaligned=0.
REQ-036 Reset SHALL take priority over commit, fetch and TRAP in any state; a pending memory request SHALL be abandoned.

Verification
REQ-037 Sequential fetch: reset, imemReady=1 each REQ cycle, stall=0, no branch -> pc steps 0,4,8,C; instrCount=4 after 8 cycles.
REQ-038 Taken branch: at pc=8, branch=1, zero=1, target=32'h40 -> next imemAddr=0x40; with zero=0 instead -> 0xC.
REQ-039 Memory wait plus stall: imemReady low for 3 cycles -> imemReq held, pc stable; stall=1 for 2 HOLD cycles -> instr and instrCount unchanged.
REQ-040 Misaligned jump: forceJump=1, target=32'h22 -> TRAP next cycle, misaligned=1, instrValid=0, imemReq=0; reset clears to pc=RESET_PC.
REQ-041 Mid-fetch reset and wrap: reset during REQ -> pc=RESET_PC next cycle; instrCount preloaded to 32'hFFFF_FFFF plus one commit -> 0.
